// File: rtl/reg_read_unit_pkg.sv
// rtl/reg_read_unit_pkg.sv - shared widths, zero-register index and forwarding select helper
package reg_read_unit_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_ARRAY
  } fwd_sel_e;

  // Youngest producer wins; r0 and disabled ports never see forwarded data.
  function automatic fwd_sel_e fwd_select(input logic read_en, input logic addr_zero,
                                          input logic ex_hit, input logic mem_hit,
                                          input logic wb_hit);
    if (!read_en || addr_zero) return FWD_ZERO;
    if (ex_hit)                return FWD_EX;
    if (mem_hit)               return FWD_MEM;
    if (wb_hit)                return FWD_WB;
    return FWD_ARRAY;
  endfunction

endpackage

// File: rtl/reg_read_unit_if.sv
// rtl/reg_read_unit_if.sv - operand read requests, pipeline write-back buses and forwarded operands
interface reg_read_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic                  ex_write_en;
  logic [ADDR_WIDTH-1:0] ex_write_addr;
  logic [DATA_WIDTH-1:0] ex_write_data;
  logic                  ex_load_flag;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  wb_write_en;
  logic [ADDR_WIDTH-1:0] wb_write_addr;
  logic [DATA_WIDTH-1:0] wb_write_data;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic                  load_stall_req;

  modport master (
    output read_en_1, read_addr_1, read_en_2, read_addr_2,
           ex_write_en, ex_write_addr, ex_write_data, ex_load_flag,
           mem_write_en, mem_write_addr, mem_write_data,
           wb_write_en, wb_write_addr, wb_write_data,
    input  read_data_1, read_data_2, load_stall_req
  );

  modport slave (
    input  read_en_1, read_addr_1, read_en_2, read_addr_2,
           ex_write_en, ex_write_addr, ex_write_data, ex_load_flag,
           mem_write_en, mem_write_addr, mem_write_data,
           wb_write_en, wb_write_addr, wb_write_data,
    output read_data_1, read_data_2, load_stall_req
  );
endinterface

// File: rtl/reg_file_core.sv
// rtl/reg_file_core.sv - GPR array with synchronous clear, one write port and two async read ports
module reg_file_core
  import reg_read_unit_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int REG_NUM    = REG_COUNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  logic [DATA_WIDTH-1:0] regs [REG_NUM];

  // r0 is never written, so it reads zero without a dedicated read-side mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (write_en && write_addr != REG_ZERO) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_data_1 = regs[read_addr_1];
  assign read_data_2 = regs[read_addr_2];

endmodule

// File: rtl/reg_read_unit.sv
// rtl/reg_read_unit.sv - ID-stage operand read with EX/MEM/WB forwarding and load-use stall detection
module reg_read_unit
  import reg_read_unit_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int REG_NUM    = REG_COUNT
) (
  input logic             clk,
  input logic             rst,
  reg_read_unit_if.slave  bus
);

  logic [DATA_WIDTH-1:0] array_data_1;
  logic [DATA_WIDTH-1:0] array_data_2;
  fwd_sel_e              sel_1;
  fwd_sel_e              sel_2;
  logic                  ex_hit_1;
  logic                  ex_hit_2;

  reg_file_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .REG_NUM   (REG_NUM)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .write_en   (bus.wb_write_en),
    .write_addr (bus.wb_write_addr),
    .write_data (bus.wb_write_data),
    .read_addr_1(bus.read_addr_1),
    .read_addr_2(bus.read_addr_2),
    .read_data_1(array_data_1),
    .read_data_2(array_data_2)
  );

  assign ex_hit_1 = bus.ex_write_en && bus.ex_write_addr == bus.read_addr_1;
  assign ex_hit_2 = bus.ex_write_en && bus.ex_write_addr == bus.read_addr_2;

  assign sel_1 = fwd_select(bus.read_en_1, bus.read_addr_1 == REG_ZERO, ex_hit_1,
                            bus.mem_write_en && bus.mem_write_addr == bus.read_addr_1,
                            bus.wb_write_en && bus.wb_write_addr == bus.read_addr_1);
  assign sel_2 = fwd_select(bus.read_en_2, bus.read_addr_2 == REG_ZERO, ex_hit_2,
                            bus.mem_write_en && bus.mem_write_addr == bus.read_addr_2,
                            bus.wb_write_en && bus.wb_write_addr == bus.read_addr_2);

  always_comb begin
    bus.read_data_1 = '0;
    case (sel_1)
      FWD_EX:    bus.read_data_1 = bus.ex_write_data;
      FWD_MEM:   bus.read_data_1 = bus.mem_write_data;
      FWD_WB:    bus.read_data_1 = bus.wb_write_data;
      FWD_ARRAY: bus.read_data_1 = array_data_1;
      default:   bus.read_data_1 = '0;
    endcase
  end

  always_comb begin
    bus.read_data_2 = '0;
    case (sel_2)
      FWD_EX:    bus.read_data_2 = bus.ex_write_data;
      FWD_MEM:   bus.read_data_2 = bus.mem_write_data;
      FWD_WB:    bus.read_data_2 = bus.wb_write_data;
      FWD_ARRAY: bus.read_data_2 = array_data_2;
      default:   bus.read_data_2 = '0;
    endcase
  end

  // Load data only exists after MEM, so an operand hit on a load in EX must wait a cycle.
  assign bus.load_stall_req = bus.ex_load_flag && bus.ex_write_en &&
                              bus.ex_write_addr != REG_ZERO &&
                              ((bus.read_en_1 && ex_hit_1) || (bus.read_en_2 && ex_hit_2));

endmodule

// File: tb/tb_reg_read_unit.sv
// tb/tb_reg_read_unit.sv - directed self-checking bench for reg_read_unit
module tb_reg_read_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  reg_read_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_read_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_NUM(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bus.read_en_1      = 1'b0;
    bus.read_addr_1    = '0;
    bus.read_en_2      = 1'b0;
    bus.read_addr_2    = '0;
    bus.ex_write_en    = 1'b0;
    bus.ex_write_addr  = '0;
    bus.ex_write_data  = '0;
    bus.ex_load_flag   = 1'b0;
    bus.mem_write_en   = 1'b0;
    bus.mem_write_addr = '0;
    bus.mem_write_data = '0;
    bus.wb_write_en    = 1'b0;
    bus.wb_write_addr  = '0;
    bus.wb_write_data  = '0;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_write_en = en; bus.wb_write_addr = addr; bus.wb_write_data = data;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_all();
    rst = 1'b1;
    @(posedge clk);

    // Reset: array reads 0, forwarding still passes through
    next_cycle();
    bus.read_en_1 = 1'b1; bus.read_addr_1 = 5'd5;
    #1 check("rst_read_r5", bus.read_data_1, 32'h0);
    check("rst_no_stall", {31'b0, bus.load_stall_req}, 32'h0);
    wb(1'b1, 5'd5, 32'h1234);
    #1 check("rst_wb_through", bus.read_data_1, 32'h1234);
    next_cycle();
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    #1 check("rst_wb_dropped", bus.read_data_1, 32'h0);

    // WB write-through then array visibility
    wb(1'b1, 5'd8, 32'hDEADBEEF);
    bus.read_addr_1 = 5'd8;
    #1 check("wb_through_r8", bus.read_data_1, 32'hDEADBEEF);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    #1 check("array_r8", bus.read_data_1, 32'hDEADBEEF);

    // Priority EX > MEM > WB > array on r3
    wb(1'b1, 5'd3, 32'h11);
    next_cycle();
    wb(1'b0, 5'd0, 32'h0);
    bus.read_en_2 = 1'b1; bus.read_addr_2 = 5'd3;
    bus.mem_write_en = 1'b1; bus.mem_write_addr = 5'd3; bus.mem_write_data = 32'h22;
    bus.ex_write_en  = 1'b1; bus.ex_write_addr  = 5'd3; bus.ex_write_data  = 32'h33;
    #1 check("prio_ex", bus.read_data_2, 32'h33);
    check("prio_no_stall", {31'b0, bus.load_stall_req}, 32'h0);
    wb(1'b1, 5'd3, 32'h44);
    #1 check("prio_ex_over_wb", bus.read_data_2, 32'h33);
    bus.ex_write_en = 1'b0;
    #1 check("prio_mem", bus.read_data_2, 32'h22);
    bus.mem_write_en = 1'b0;
    #1 check("prio_wb", bus.read_data_2, 32'h44);
    wb(1'b0, 5'd0, 32'h0);
    #1 check("prio_array", bus.read_data_2, 32'h11);
    bus.read_addr_1 = 5'd3;
    #1 check("same_reg_p1", bus.read_data_1, 32'h11);
    check("same_reg_p2", bus.read_data_2, 32'h11);

    // r0 never forwarded, never stalls
    next_cycle();
    bus.read_en_2 = 1'b0;
    bus.read_addr_1 = 5'd0;
    bus.ex_write_en  = 1'b1; bus.ex_write_addr  = 5'd0; bus.ex_write_data  = 32'hFFFFFFFF;
    bus.ex_load_flag = 1'b1;
    bus.mem_write_en = 1'b1; bus.mem_write_addr = 5'd0; bus.mem_write_data = 32'hFFFFFFFF;
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    #1 check("r0_fwd", bus.read_data_1, 32'h0);
    check("r0_no_stall", {31'b0, bus.load_stall_req}, 32'h0);
    next_cycle();
    idle_all();
    bus.read_en_1 = 1'b1; bus.read_addr_1 = 5'd0;
    #1 check("r0_array", bus.read_data_1, 32'h0);

    // Load-use stall
    bus.read_en_1 = 1'b0;
    bus.ex_write_en = 1'b1; bus.ex_write_addr = 5'd9; bus.ex_write_data = 32'hAAAA5555;
    bus.ex_load_flag = 1'b1;
    bus.read_en_2 = 1'b1; bus.read_addr_2 = 5'd9;
    #1 check("lu_stall_p2", {31'b0, bus.load_stall_req}, 32'h1);
    check("lu_data_p2", bus.read_data_2, 32'hAAAA5555);
    bus.read_en_2 = 1'b0;
    #1 check("lu_p2_disabled", {31'b0, bus.load_stall_req}, 32'h0);
    check("lu_p2_dis_data", bus.read_data_2, 32'h0);
    bus.read_en_1 = 1'b1; bus.read_addr_1 = 5'd9;
    #1 check("lu_stall_p1", {31'b0, bus.load_stall_req}, 32'h1);
    bus.read_en_1 = 1'b0;
    bus.read_en_2 = 1'b1;
    bus.ex_load_flag = 1'b0;
    #1 check("lu_no_load", {31'b0, bus.load_stall_req}, 32'h0);
    check("lu_no_load_data", bus.read_data_2, 32'hAAAA5555);
    bus.ex_load_flag = 1'b1; bus.ex_write_en = 1'b0;
    #1 check("lu_no_we", {31'b0, bus.load_stall_req}, 32'h0);

    // Disabled read of a populated register
    next_cycle();
    idle_all();
    bus.read_en_1 = 1'b0; bus.read_addr_1 = 5'd8;
    #1 check("dis_read", bus.read_data_1, 32'h0);
    check("dis_no_stall", {31'b0, bus.load_stall_req}, 32'h0);
    bus.read_en_1 = 1'b1;
    #1 check("en_read_r8", bus.read_data_1, 32'hDEADBEEF);

    // Second reset clears written entries
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1 check("rst2_r8", bus.read_data_1, 32'h0);
    bus.read_addr_1 = 5'd3;
    #1 check("rst2_r3", bus.read_data_1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_read_unit.md
Name: reg_read_unit

Overview:
- ID-stage register read unit, directly downstream of the ID register-address generator.
- Consumes the two read enables/addresses produced for the current instruction and holds the 32-entry architectural GPR array.
- Returns forwarded operands for the instruction in ID, taking EX, MEM and WB results into account.
- Raises a load-use stall request when an operand depends on a load still in EX.

Parameters:
DATA_WIDTH, 32, GPR and operand width
ADDR_WIDTH, 5, register address width (matches REG_ADDR_BUS)
REG_NUM, 32, number of GPRs; index 0 is hard-wired zero

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
read_en_1  input  1  operand 1 read enable from ID address generator
read_addr_1  input  ADDR_WIDTH  operand 1 register index
read_en_2  input  1  operand 2 read enable
read_addr_2  input  ADDR_WIDTH  operand 2 register index
ex_write_en  input  1  instruction in EX writes a GPR
ex_write_addr  input  ADDR_WIDTH  EX destination
ex_write_data  input  DATA_WIDTH  EX ALU result
ex_load_flag  input  1  instruction in EX is LB/LBU/LW (data not yet available)
mem_write_en  input  1  instruction in MEM writes a GPR
mem_write_addr  input  ADDR_WIDTH  MEM destination
mem_write_data  input  DATA_WIDTH  MEM result (load data already resolved)
wb_write_en  input  1  WB write port enable
wb_write_addr  input  ADDR_WIDTH  WB destination
wb_write_data  input  DATA_WIDTH  WB data
read_data_1  output  DATA_WIDTH  forwarded operand 1 (combinational)
read_data_2  output  DATA_WIDTH  forwarded operand 2 (combinational)
load_stall_req  output  1  load-use stall request to pipeline controller (combinational)

Behaviour:
- Storage: REG_NUM x DATA_WIDTH array, one write port (WB), two combinational read ports.
- Reset: on rising clk with rst=1, all entries cleared to 0; WB write suppressed that cycle.
- Outputs while rst is asserted are defined by the forwarding rules below: array reads give 0, forwarded values still pass through; load_stall_req is combinational, not forced.
- Write: on rising clk with rst=0, wb_write_en=1 and wb_write_addr!=0, array[wb_write_addr] <= wb_write_data. Writes to r0 are discarded.
- Read, per port independently, first match wins:
  1. read_en=0 -> 0.
  2. addr=0 -> 0. Never forwarded, even if a stage targets r0.
  3. ex_write_en && ex_write_addr==addr -> ex_write_data.
  4. mem_write_en && mem_write_addr==addr -> mem_write_data.
  5. wb_write_en && wb_write_addr==addr -> wb_write_data (write-through, same cycle as the write).
  6. Otherwise -> array[addr].
- Youngest producer wins: EX over MEM over WB.
- load_stall_req = ex_load_flag && ex_write_en && ex_write_addr!=0 && ((read_en_1 && read_addr_1==ex_write_addr) || (read_en_2 && read_addr_2==ex_write_addr)).
  - When asserted, read_data still follows rule 3. The value is don't-care; the controller holds ID and bubbles EX.
- Both ports may address the same register; each gets the identical value.
- Zero-cycle latency from read address to data.
- One-cycle latency from WB write to array visibility; hidden by rule 5.

Decomposition:
- Use the shared bus.v macros REG_ADDR_BUS and REG_BUS (DATA_WIDTH) so widths match the ID address generator.
- Add a REG_ZERO constant (5'd0) to the shared header.
- One sub-module: reg_file_core, holding the plain array with synchronous reset/write and two async read ports.
- reg_read_unit wraps reg_file_core with the forwarding muxes and stall detection.

Test Plan:
- Reset then read: rst=1 one cycle; read_en_1=1 addr=5 -> read_data_1=0. WB write r5=0x1234 during rst is ignored; after release, reading r5 gives 0.
- WB write and write-through: wb_write_en=1 addr=8 data=0xDEADBEEF, read addr_1=8 same cycle -> 0xDEADBEEF. Next cycle with wb_write_en=0 -> 0xDEADBEEF from the array.
- Priority: r3 in array=0x11; mem writes r3=0x22; ex writes r3=0x33 -> read_data_2=0x33. Drop ex_write_en -> 0x22. Drop mem -> 0x11.
- r0 handling: ex/mem/wb all target r0 with 0xFFFFFFFF, read_addr_1=0 en=1 -> 0; load_stall_req=0. Next cycle, array r0 still reads 0.
- Load-use: ex_load_flag=1 ex_write_addr=9, read_en_2=1 addr=9 -> load_stall_req=1. Same with read_en_2=0 -> 0. With ex_load_flag=0 -> 0 and data=ex_write_data.
- Disabled read: read_en_1=0 addr=8 with r8=0xDEADBEEF -> read_data_1=0, no stall.
